// File: rtl/decode_stage.sv
// decode_stage: pipelined addi/bne/lw decoder with load-use bubble, flush and issue/bubble counters
module decode_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALU_WIDTH     = 3,
  parameter int IMM_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  input  logic [DATA_WIDTH-1:0]    pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    pc_o,
  output logic [ADDRESS_WIDTH-1:0] rs1_o,
  output logic [ADDRESS_WIDTH-1:0] rs2_o,
  output logic [ADDRESS_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0]    imm_o,
  output logic [IMM_WIDTH-1:0]     imm_src_o,
  output logic [ALU_WIDTH-1:0]     alu_ctrl_o,
  output logic                     alu_src_o,
  output logic                     reg_write_o,
  output logic                     mem_read_o,
  output logic                     result_src_o,
  output logic                     branch_o,
  output logic                     illegal_o,
  output logic [31:0]              issue_count_o,
  output logic [31:0]              bubble_count_o
);
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [ALU_WIDTH-1:0] SUM_OP = ALU_WIDTH'(0);
  localparam logic [ALU_WIDTH-1:0] SUB_OP = ALU_WIDTH'(1);
  localparam logic [IMM_WIDTH-1:0] IMM_I  = IMM_WIDTH'(0);
  localparam logic [IMM_WIDTH-1:0] IMM_B  = IMM_WIDTH'(3);

  logic                     is_addi, is_lw, is_bne, legal;
  logic [ADDRESS_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  logic [DATA_WIDTH-1:0]    i_imm, b_imm, imm_d;
  logic                     hazard, in_xfer, out_xfer;
  logic                     unused;

  logic                     out_valid_q;
  logic [DATA_WIDTH-1:0]    pc_q, imm_q;
  logic [ADDRESS_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [IMM_WIDTH-1:0]     imm_src_q;
  logic [ALU_WIDTH-1:0]     alu_ctrl_q;
  logic                     alu_src_q, reg_write_q, mem_read_q, result_src_q, branch_q, illegal_q;
  logic [31:0]              issue_count_q, bubble_count_q;

  // funct3 is not needed to tell the three supported opcodes apart
  assign unused = ^instr_i[14:12];

  // Field extraction and opcode decode of the incoming word
  always_comb begin
    is_addi  = instr_i[6:0] == OP_ADDI;
    is_lw    = instr_i[6:0] == OP_LW;
    is_bne   = instr_i[6:0] == OP_BNE;
    legal    = is_addi | is_lw | is_bne;
    rs1_d    = instr_i[15 +: ADDRESS_WIDTH];
    rs2_d    = instr_i[20 +: ADDRESS_WIDTH];
    rd_d     = instr_i[7 +: ADDRESS_WIDTH];
    i_imm    = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    b_imm    = {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    imm_d    = is_bne ? b_imm : legal ? i_imm : '0;
    hazard   = in_valid_i & out_valid_q & mem_read_q & (rd_q != '0) &
               ((legal & (rs1_d == rd_q)) | (is_bne & (rs2_d == rd_q)));
    in_ready_o = ~flush_i & ~hazard & (~out_valid_q | out_ready_i);
    in_xfer  = in_valid_i & in_ready_o;
    out_xfer = out_valid_q & out_ready_i;
  end

  // Decode/execute register plus issue and bubble counters
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      imm_src_q      <= '0;
      alu_ctrl_q     <= '0;
      alu_src_q      <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      result_src_q   <= 1'b0;
      branch_q       <= 1'b0;
      illegal_q      <= 1'b0;
      issue_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (in_xfer) begin
        out_valid_q  <= 1'b1;
        pc_q         <= pc_i;
        imm_q        <= imm_d;
        rs1_q        <= rs1_d;
        rs2_q        <= rs2_d;
        rd_q         <= rd_d;
        imm_src_q    <= is_bne ? IMM_B : IMM_I;
        alu_ctrl_q   <= is_bne ? SUB_OP : SUM_OP;
        alu_src_q    <= is_addi | is_lw;
        reg_write_q  <= is_addi | is_lw;
        mem_read_q   <= is_lw;
        result_src_q <= is_lw;
        branch_q     <= is_bne;
        illegal_q    <= ~legal;
      end else if (flush_i | out_xfer) begin
        out_valid_q  <= 1'b0;
      end
      if (~flush_i & out_xfer & ~illegal_q) issue_count_q <= issue_count_q + 32'd1;
      if (~flush_i & hazard & out_ready_i) bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign pc_o           = pc_q;
  assign rs1_o          = rs1_q;
  assign rs2_o          = rs2_q;
  assign rd_o           = rd_q;
  assign imm_o          = imm_q;
  assign imm_src_o      = imm_src_q;
  assign alu_ctrl_o     = alu_ctrl_q;
  assign alu_src_o      = alu_src_q;
  assign reg_write_o    = reg_write_q;
  assign mem_read_o     = mem_read_q;
  assign result_src_o   = result_src_q;
  assign branch_o       = branch_q;
  assign illegal_o      = illegal_q;
  assign issue_count_o  = issue_count_q;
  assign bubble_count_o = bubble_count_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized checking of decode_stage against a behavioural model
module tb_decode_stage;
  logic        clk = 0, rst, flush_i, in_valid_i, out_ready_i;
  logic [31:0] instr_i, pc_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] pc_o, imm_o, issue_count_o, bubble_count_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  imm_src_o, alu_ctrl_o;
  logic        alu_src_o, reg_write_o, mem_read_o, result_src_o, branch_o, illegal_o;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o), .imm_src_o(imm_src_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_src_o(alu_src_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .result_src_o(result_src_o), .branch_o(branch_o), .illegal_o(illegal_o),
    .issue_count_o(issue_count_o), .bubble_count_o(bubble_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  imm_src, alu_ctrl;
    logic        alu_src, reg_write, mem_read, result_src, branch, illegal;
  } dec_t;

  dec_t        m_out;
  logic        m_valid, m_ready, m_acc;
  logic [31:0] m_issue, m_bubble;
  int          vectors = 0, ncmp = 0, errs = 0;

  function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d = '0;
    int   v;
    d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
    case (ins[6:0])
      7'h13, 7'h03: begin
        v = int'(ins[31:20]);
        if (v >= 2048) v -= 4096;
        d.imm = v; d.alu_src = 1; d.reg_write = 1;
        d.mem_read = ins[6:0] == 7'h03; d.result_src = ins[6:0] == 7'h03;
      end
      7'h63: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) v -= 8192;
        d.imm = v; d.imm_src = 3; d.alu_ctrl = 1; d.branch = 1;
      end
      default: d.illegal = 1;
    endcase
    return d;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic ordy);
    dec_t d;
    logic haz, in_x, out_x;
    rst = r; flush_i = f; in_valid_i = v; instr_i = ins; pc_i = pc; out_ready_i = ordy;
    #1;
    d   = decode(ins, pc);
    haz = v && m_valid && m_out.mem_read && m_out.rd != 0 &&
          ((!d.illegal && d.rs1 == m_out.rd) || (d.branch && d.rs2 == m_out.rd));
    m_ready = !f && !haz && (!m_valid || ordy);
    vectors++;
    cmp("in_ready", 32'(in_ready_o), 32'(m_ready));
    cmp("out_valid", 32'(out_valid_o), 32'(m_valid));
    cmp("fields", {pc_o, imm_o, rs1_o, rs2_o, rd_o, imm_src_o, alu_ctrl_o} == {m_out.pc, m_out.imm,
        m_out.rs1, m_out.rs2, m_out.rd, m_out.imm_src, m_out.alu_ctrl} ? 32'd1 : 32'd0, 32'd1);
    cmp("ctrl", 32'({alu_src_o, reg_write_o, mem_read_o, result_src_o, branch_o, illegal_o}),
        32'({m_out.alu_src, m_out.reg_write, m_out.mem_read, m_out.result_src, m_out.branch, m_out.illegal}));
    cmp("issue_count", issue_count_o, m_issue);
    cmp("bubble_count", bubble_count_o, m_bubble);
    in_x = v && m_ready; out_x = m_valid && ordy;
    m_acc = in_x && !r;
    if (r) begin
      m_valid = 0; m_out = '0; m_issue = 0; m_bubble = 0;
    end else begin
      if (!f && out_x && !m_out.illegal) m_issue++;
      if (!f && haz && ordy) m_bubble++;
      if (in_x) begin m_out = d; m_valid = 1; end
      else if (f || out_x) m_valid = 0;
    end
    @(negedge clk);
  endtask

  logic [31:0] cur_ins, cur_pc;
  logic        cur_v;
  logic [6:0]  ops [4] = '{7'h13, 7'h03, 7'h63, 7'h33};

  initial begin
    m_valid = 0; m_out = '0; m_issue = 0; m_bubble = 0;
    rst = 1; flush_i = 0; in_valid_i = 0; instr_i = 0; pc_i = 0; out_ready_i = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    cmp("rst_valid", 32'(out_valid_o), 0);
    cmp("rst_imm", imm_o, 0);
    cmp("rst_issue", issue_count_o, 0);
    // addi x5,x0,-1
    step(0, 0, 1, 32'hFFF00293, 32'h0, 1);
    cmp("t1_valid", 32'(out_valid_o), 1);
    cmp("t1_rd", 32'(rd_o), 5);
    cmp("t1_rs1", 32'(rs1_o), 0);
    cmp("t1_imm", imm_o, 32'hFFFFFFFF);
    cmp("t1_ctrl", 32'({alu_ctrl_o, alu_src_o, reg_write_o}), 32'b000_1_1);
    step(0, 0, 0, 0, 0, 1);
    cmp("t1_issue", issue_count_o, 1);
    // lw x6,4(x5) then dependent bne
    step(0, 0, 1, 32'h0042A303, 32'h4, 1);
    cmp("t2_lw_imm", imm_o, 4);
    cmp("t2_lw_mem", 32'({mem_read_o, result_src_o, rd_o}), {25'd0, 1'b1, 1'b1, 5'd6});
    step(0, 0, 1, 32'hFE031EE3, 32'h8, 1);
    cmp("t2_bubble_valid", 32'(out_valid_o), 0);
    cmp("t2_bubble_cnt", bubble_count_o, 1);
    cmp("t2_ready_after", 32'(in_ready_o), 1);
    step(0, 0, 1, 32'hFE031EE3, 32'h8, 1);
    cmp("t2_bne_rs1", 32'(rs1_o), 6);
    cmp("t2_bne_imm", imm_o, 32'hFFFFFFFC);
    cmp("t2_bne_ctrl", 32'({alu_ctrl_o, branch_o, imm_src_o}), 32'b001_1_011);
    step(0, 0, 0, 0, 0, 1);
    cmp("t2_issue", issue_count_o, 3);
    // backpressure
    step(0, 0, 1, 32'h00100093, 32'h10, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 32'h00200113, 32'h14, 0);
      cmp("t3_ready", 32'(in_ready_o), 0);
      cmp("t3_pc_hold", pc_o, 32'h10);
    end
    step(0, 0, 1, 32'h00200113, 32'h14, 1);
    cmp("t3_pc_new", pc_o, 32'h14);
    cmp("t3_issue", issue_count_o, 4);
    // flush
    step(0, 1, 1, 32'h00300193, 32'h18, 1);
    cmp("t4_ready", 32'(in_ready_o), 0);
    cmp("t4_valid", 32'(out_valid_o), 0);
    cmp("t4_issue", issue_count_o, 4);
    step(0, 0, 1, 32'h00300193, 32'h18, 1);
    cmp("t4_accept", pc_o, 32'h18);
    // illegal opcode
    step(0, 0, 1, 32'h00000033, 32'h1C, 1);
    cmp("t5_illegal", 32'({out_valid_o, illegal_o, reg_write_o}), 32'b110);
    cmp("t5_imm", imm_o, 0);
    step(0, 0, 0, 0, 0, 1);
    cmp("t5_issue", issue_count_o, 5);
    // reset during hazard stall
    step(0, 0, 1, 32'h0042A303, 32'h20, 1);
    step(0, 0, 1, 32'hFE031EE3, 32'h24, 0);
    cmp("t6_hold", 32'({out_valid_o, mem_read_o}), 32'b11);
    step(1, 0, 1, 32'hFE031EE3, 32'h24, 0);
    cmp("t6_valid", 32'(out_valid_o), 0);
    cmp("t6_counts", issue_count_o | bubble_count_o, 0);
    step(0, 0, 0, 0, 0, 0);
    cmp("t6_ready", 32'(in_ready_o), 1);
    // randomized traffic; upstream holds an offered word until it is taken
    cur_v = 0; cur_ins = 0; cur_pc = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!cur_v || m_acc) begin
        cur_v = $urandom_range(0, 3) != 0;
        cur_ins = $urandom;
        cur_ins[6:0] = ops[$urandom_range(0, 3)];
        cur_ins[11:7] = 5'($urandom_range(0, 3));
        cur_ins[19:15] = 5'($urandom_range(0, 3));
        cur_ins[24:20] = 5'($urandom_range(0, 3));
        cur_pc = cur_pc + 4;
      end
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, cur_v, cur_ins, cur_pc,
           $urandom_range(0, 9) < 7);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
